// File: rtl/phase_sequencer.sv
// phase_sequencer: traffic-light phase sequencer driven by a tick timebase.
// Steps through RED -> GREEN(p) -> YELLOW(p) and back. The phase p is latched
// when green is entered and decides both the lamp codes and the green length.
// Optional feature macro: ALL_RED_CLEARANCE_EN
//   defined   : YELLOW(p) -> RED -> GREEN(current_phase); RED lasts RED_TICKS.
//   undefined : RED appears only after reset and lasts a single tick, and
//               YELLOW(p) goes directly to GREEN(current_phase).
module phase_sequencer #(
  parameter int GREEN_TICKS      = 20,
  parameter int PRIO_GREEN_TICKS = 10,
  parameter int YELLOW_TICKS     = 4,
  parameter int RED_TICKS        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [1:0]  current_phase,
  output logic [3:0]  light_state,
  output logic        state_done,
  output logic [15:0] remaining
);

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  // A duration of 0 behaves as 1; longer durations keep the low 16 bits of
  // (duration - 1).
  function automatic logic [15:0] dur_m1(input int d);
    if (d <= 1) return 16'd0;
    else        return 16'(d - 1);
  endfunction

  localparam logic [15:0] GREEN_M1  = dur_m1(GREEN_TICKS);
  localparam logic [15:0] PRIO_M1   = dur_m1(PRIO_GREEN_TICKS);
  localparam logic [15:0] YELLOW_M1 = dur_m1(YELLOW_TICKS);
  localparam logic [15:0] RED_M1    = dur_m1(RED_TICKS);

`ifdef ALL_RED_CLEARANCE_EN
  localparam logic [15:0] RST_M1 = RED_M1;
`else
  // Without clearance, the post-reset red is always one tick; RED_TICKS has
  // no effect in this build.
  localparam logic [15:0] RST_M1 = RED_M1 & 16'd0;
`endif

  // Phases 0/1 are the main phases; 2/3 are the shorter priority phases.
  function automatic logic [15:0] green_m1(input logic [1:0] p);
    return p[1] ? PRIO_M1 : GREEN_M1;
  endfunction

  // Lamp code: green = 2p+1, yellow = 2p+2, all-red = 0.
  function automatic logic [3:0] encode(input state_t s, input logic [1:0] p);
    case (s)
      ST_GREEN:  return 4'({p, 1'b0}) + 4'd1;
      ST_YELLOW: return 4'({p, 1'b0}) + 4'd2;
      default:   return 4'd0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [15:0] remaining_q, remaining_d;
  logic [3:0]  light_state_q, light_state_d;
  logic        state_done_q, state_done_d;

  // Next state: count down on ticks; a tick at zero moves to the next state
  // and reloads the counter for it.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    remaining_d   = remaining_q;
    state_done_d  = 1'b0;
    if (tick) begin
      if (remaining_q != 16'd0) begin
        remaining_d = remaining_q - 16'd1;
      end else begin
        state_done_d = 1'b1;
        case (state_q)
          ST_GREEN: begin
            state_d     = ST_YELLOW;
            remaining_d = YELLOW_M1;
          end
          ST_YELLOW: begin
`ifdef ALL_RED_CLEARANCE_EN
            state_d     = ST_RED;
            remaining_d = RED_M1;
`else
            state_d     = ST_GREEN;
            phase_d     = current_phase;
            remaining_d = green_m1(current_phase);
`endif
          end
          default: begin
            state_d     = ST_GREEN;
            phase_d     = current_phase;
            remaining_d = green_m1(current_phase);
          end
        endcase
      end
    end
    light_state_d = encode(state_d, phase_d);
  end

  // State and registered outputs; reset wins over tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RED;
      phase_q       <= 2'd0;
      remaining_q   <= RST_M1;
      light_state_q <= 4'd0;
      state_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      remaining_q   <= remaining_d;
      light_state_q <= light_state_d;
      state_done_q  <= state_done_d;
    end
  end

  assign light_state = light_state_q;
  assign state_done  = state_done_q;
  assign remaining   = remaining_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed testbench for phase_sequencer (GREEN=4, PRIO=3, YELLOW=2, RED=1),
// plus a second instance with every duration set to 0.
// Expectations follow the ALL_RED_CLEARANCE_EN setting of the build.
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [1:0]  cp;
  logic [1:0]  cp_z;
  logic [3:0]  light, light_z;
  logic        done, done_z;
  logic [15:0] rem, rem_z;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int green_cnt;

  always #5 clk = ~clk;

  phase_sequencer #(
    .GREEN_TICKS(4), .PRIO_GREEN_TICKS(3), .YELLOW_TICKS(2), .RED_TICKS(1)
  ) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .current_phase(cp),
    .light_state(light), .state_done(done), .remaining(rem)
  );

  phase_sequencer #(
    .GREEN_TICKS(0), .PRIO_GREEN_TICKS(0), .YELLOW_TICKS(0), .RED_TICKS(0)
  ) u_zero (
    .clk(clk), .rst(rst), .tick(tick), .current_phase(cp_z),
    .light_state(light_z), .state_done(done_z), .remaining(rem_z)
  );

`ifdef ALL_RED_CLEARANCE_EN
  localparam int N = 14;
  int exp_l[N] = '{1, 1, 1, 1, 2, 2, 0, 5, 5, 5, 6, 6, 0, 7};
  int exp_r[N] = '{3, 2, 1, 0, 1, 0, 0, 2, 1, 0, 1, 0, 0, 2};
  int exp_d[N] = '{1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1};
  localparam int CP3_AT = 9;
  int exp_z[6] = '{1, 2, 0, 1, 2, 0};
`else
  localparam int N = 12;
  int exp_l[N] = '{1, 1, 1, 1, 2, 2, 5, 5, 5, 6, 6, 7};
  int exp_r[N] = '{3, 2, 1, 0, 1, 0, 2, 1, 0, 1, 0, 2};
  int exp_d[N] = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 1};
  localparam int CP3_AT = 8;
  int exp_z[6] = '{1, 2, 1, 2, 1, 2};
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int want);
    total_cnt++;
    assert (got === want) pass_cnt++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  task automatic chk3(input string tag, input int l, input int r, input int d);
    chk({tag, ".light"}, int'(light), l);
    chk({tag, ".rem"},   int'(rem),   r);
    chk({tag, ".done"},  int'(done),  d);
  endtask

  task automatic do_reset(input logic [1:0] phase);
    rst  = 1'b1;
    tick = 1'b1;
    cp   = phase;
    cp_z = 2'd0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state, with tick held high to show reset wins.
    do_reset(2'd0);
    chk3("reset", 0, 0, 0);

    // Main sequence; phase change mid-green is ignored until the next entry.
    for (int i = 0; i < N; i++) begin
      step();
      chk3($sformatf("seq%0d", i + 1), exp_l[i], exp_r[i], exp_d[i]);
      if (i == 1) cp = 2'd2;
      if (i == CP3_AT - 1) cp = 2'd3;
    end

    // Tick every third cycle: phase-1 green spans 12 clock cycles.
    do_reset(2'd0);
    green_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick = (i % 3 == 2);
      step();
      if (light == 4'd1) green_cnt++;
    end
    chk("slow_tick.green_cycles", green_cnt, 12);

    // tick held low for 50 cycles mid-green freezes everything.
    do_reset(2'd0);
    step();
    step();
    chk3("pre_freeze", 1, 2, 0);
    tick = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk3("freeze", 1, 2, 0);
    end
    tick = 1'b1;
    step();
    chk3("thaw", 1, 1, 0);

    // Reset during phase-2 green with remaining=2.
    do_reset(2'd1);
    step();
    chk3("p2_green", 3, 3, 1);
    step();
    chk3("p2_green2", 3, 2, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk3("mid_reset", 0, 0, 0);
    step();
    chk3("after_reset", 3, 3, 1);

    // Zero durations: one state per cycle, state_done every cycle.
    do_reset(2'd0);
    chk("zero.reset_light", int'(light_z), 0);
    chk("zero.reset_done", int'(done_z), 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("zero%0d.light", i), int'(light_z), exp_z[i]);
      chk($sformatf("zero%0d.rem", i), int'(rem_z), 0);
      chk($sformatf("zero%0d.done", i), int'(done_z), 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
